// File: rtl/ser2par_10b.sv
// 1:10 deserializer with TMDS control-token word alignment (SEARCH/VERIFY/LOCKED).
// Optional slip statistics counter enabled by defining SER2PAR_10B_STAT_EN.
module ser2par_10b #(
  parameter int unsigned LOCK_CNT   = 4,
  parameter int unsigned UNLOCK_CNT = 8
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic       ser_data_i,
  input  logic       ser_valid_i,
  output logic [9:0] par_data_o,
  output logic       par_valid_o,
  output logic       locked_o
`ifdef SER2PAR_10B_STAT_EN
  ,
  output logic [15:0] slip_cnt_o
`endif
);

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } state_t;

  localparam logic [3:0] LOCK_THR   = 4'(LOCK_CNT);
  localparam logic [3:0] UNLOCK_THR = 4'(UNLOCK_CNT);

  state_t     state;
  logic [9:0] sr;
  logic [3:0] phase;
  logic [3:0] match_cnt;
  logic [3:0] miss_cnt;
  logic [9:0] window;
  logic       hit;
  logic       boundary;

  // The window includes the bit arriving this cycle, i.e. the next value of sr.
  assign window   = {ser_data_i, sr[9:1]};
  assign boundary = (phase == 4'd9);

  always_comb begin
    hit = 1'b0;
    if (window == 10'h354 || window == 10'h0AB ||
        window == 10'h154 || window == 10'h2AB)
      hit = 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state       <= SEARCH;
      sr          <= '0;
      phase       <= '0;
      match_cnt   <= '0;
      miss_cnt    <= '0;
      par_data_o  <= '0;
      par_valid_o <= 1'b0;
      locked_o    <= 1'b0;
`ifdef SER2PAR_10B_STAT_EN
      slip_cnt_o  <= '0;
`endif
    end else begin
      par_valid_o <= 1'b0;
      if (ser_valid_i) begin
        sr    <= window;
        phase <= boundary ? 4'd0 : phase + 4'd1;
        case (state)
          SEARCH: begin
            // A token hit marks the bit as word bit 9; the next bit is bit 0.
            if (hit) begin
              phase <= 4'd0;
              if (LOCK_THR == 4'd1) begin
                state     <= LOCKED;
                locked_o  <= 1'b1;
                match_cnt <= '0;
              end else begin
                state     <= VERIFY;
                match_cnt <= 4'd1;
              end
            end
          end
          VERIFY: begin
            if (boundary) begin
              if (hit) begin
                if (match_cnt + 4'd1 == LOCK_THR) begin
                  state     <= LOCKED;
                  locked_o  <= 1'b1;
                  match_cnt <= '0;
                end else begin
                  match_cnt <= match_cnt + 4'd1;
                end
              end else begin
                state     <= SEARCH;
                match_cnt <= '0;
              end
            end
          end
          LOCKED: begin
            if (boundary) begin
              par_data_o  <= window;
              par_valid_o <= 1'b1;
              if (hit)
                miss_cnt <= '0;
            end else if (hit) begin
              if (miss_cnt + 4'd1 == UNLOCK_THR) begin
                state    <= SEARCH;
                locked_o <= 1'b0;
                miss_cnt <= '0;
`ifdef SER2PAR_10B_STAT_EN
                if (slip_cnt_o != 16'hFFFF)
                  slip_cnt_o <= slip_cnt_o + 16'd1;
`endif
              end else begin
                miss_cnt <= miss_cnt + 4'd1;
              end
            end
          end
          default: begin
            state     <= SEARCH;
            locked_o  <= 1'b0;
            match_cnt <= '0;
            miss_cnt  <= '0;
          end
        endcase
      end
    end
  end

endmodule
